pll_reconfig_seq: RTL and testbench

PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

---
 rtl/pll_reconfig_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: resets a PLL, waits for a stable lock, then serves single
// output-counter reprogramming requests over an Avalon-MM reconfiguration port.
// Optional feature macro: PLL_SEQ_LOCK_TIMEOUT_EN adds a WAIT_LOCK timeout that
// raises a sticky err and retries the PLL reset; without it err is tied low.
//
// Avalon-MM handshake: a write is presented (mgmt_write=1 with address/data)
// for as long as the state sits in a WR_* state; while mgmt_waitrequest=1 the
// write and its payload are held unchanged, the first rising edge that sees
// mgmt_waitrequest=0 completes it and moves the sequencer on.
module pll_reconfig_seq #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 8,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [4:0]  cfg_cnt_sel,
    input  logic [7:0]  cfg_hi,
    input  logic [7:0]  cfg_lo,
    output logic        cfg_busy,
    output logic        cfg_ack,
    output logic        ready,
    output logic        err,
    output logic        pll_rst,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_READY     = 3'd2,
        ST_WR_MODE   = 3'd3,
        ST_WR_CNT    = 3'd4,
        ST_WR_START  = 3'd5
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
        , ST_TIMEOUT = 3'd6
`endif
    } state_t;

    localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);

`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    state_t           state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
    logic             sync1_q, sync1_d;
    logic             lock_s_q, lock_s_d;
    logic [4:0]       sel_q, sel_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       lo_q, lo_d;
    logic             pending_q, pending_d;
    logic             cfg_ack_q, cfg_ack_d;

    // State register, counters, lock synchronizer and captured request.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RST_PLL;
            rst_cnt_q <= '0;
            stb_cnt_q <= '0;
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            sel_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pending_q <= 1'b0;
            cfg_ack_q <= 1'b0;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            sync1_q   <= sync1_d;
            lock_s_q  <= lock_s_d;
            sel_q     <= sel_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pending_q <= pending_d;
            cfg_ack_q <= cfg_ack_d;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next-state logic; counters run only in their own state and restart at 0.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        stb_cnt_d = '0;
        sync1_d   = pll_locked;
        lock_s_d  = sync1_q;
        sel_d     = sel_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pending_d = pending_q;
        cfg_ack_d = 1'b0;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
        to_cnt_d  = '0;
        err_d     = err_q;
`endif
        case (state_q)
            ST_RST_PLL: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    if (stb_cnt_q == STB_LAST) begin
                        state_d   = ST_READY;
                        cfg_ack_d = pending_q;
                        pending_d = 1'b0;
                    end else begin
                        stb_cnt_d = stb_cnt_q + STB_ONE;
                    end
                end
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
                // A lock declared on the last allowed cycle wins over the timeout.
                if (state_d != ST_READY) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d   = ST_TIMEOUT;
                        err_d     = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_ONE;
                    end
                end
`endif
            end
            ST_READY: begin
                // Lock loss takes priority and silently drops a same-cycle request.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cfg_req) begin
                    state_d   = ST_WR_MODE;
                    sel_d     = cfg_cnt_sel;
                    hi_d      = cfg_hi;
                    lo_d      = cfg_lo;
                    pending_d = 1'b1;
                end
            end
            ST_WR_MODE: begin
                if (!mgmt_waitrequest) state_d = ST_WR_CNT;
            end
            ST_WR_CNT: begin
                if (!mgmt_waitrequest) state_d = ST_WR_START;
            end
            ST_WR_START: begin
                if (!mgmt_waitrequest) state_d = ST_WAIT_LOCK;
            end
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
            ST_TIMEOUT: begin
                state_d = ST_RST_PLL;
            end
`endif
            default: begin
                state_d = ST_RST_PLL;
            end
        endcase
    end

    // Avalon-MM write decode; the bus reads all zeros whenever no write is up.
    always_comb begin
        mgmt_write     = 1'b0;
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
        case (state_q)
            ST_WR_MODE: begin
                mgmt_write = 1'b1;
            end
            ST_WR_CNT: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd5;
                mgmt_writedata = {9'd0, sel_q, 1'b0, 1'b0, hi_q, lo_q};
            end
            ST_WR_START: begin
                mgmt_write   = 1'b1;
                mgmt_address = 6'd2;
            end
            default: begin
                mgmt_write = 1'b0;
            end
        endcase
    end

    assign pll_rst   = (state_q == ST_RST_PLL);
    assign ready     = (state_q == ST_READY);
    assign cfg_busy  = (state_q != ST_READY);
    assign cfg_ack   = cfg_ack_q;
    assign dbg_state = state_q;

`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: reset/lock timing, counter writes through a
// stalling Avalon-MM responder, lock loss races, reset mid-write and timeout.
module tb_pll_reconfig_seq;

    localparam int RST_CYCLES   = 16;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 100;

    logic        refclk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [4:0]  cfg_cnt_sel;
    logic [7:0]  cfg_hi;
    logic [7:0]  cfg_lo;
    logic        cfg_busy;
    logic        cfg_ack;
    logic        ready;
    logic        err;
    logic        pll_rst;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;
    logic [2:0]  dbg_state;

    int checks    = 0;
    int failures  = 0;
    int ack_count = 0;
    int wait_len  = 0;
    int wr_cycles = 0;
    bit mon_en    = 1'b0;
    logic [37:0] exp_q[$];

    pll_reconfig_seq #(
        .RST_CYCLES(RST_CYCLES),
        .LOCK_STABLE(LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .cfg_req(cfg_req),
        .cfg_cnt_sel(cfg_cnt_sel),
        .cfg_hi(cfg_hi),
        .cfg_lo(cfg_lo),
        .cfg_busy(cfg_busy),
        .cfg_ack(cfg_ack),
        .ready(ready),
        .err(err),
        .pll_rst(pll_rst),
        .pll_locked(pll_locked),
        .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Responder stalls each write for wait_len cycles; monitor scores writes.
    initial begin
        mgmt_waitrequest = 1'b0;
        forever begin
            @(negedge refclk);
            if (mgmt_write === 1'b1 && wr_cycles < wait_len) begin
                mgmt_waitrequest = 1'b1;
                wr_cycles++;
            end else begin
                mgmt_waitrequest = 1'b0;
                wr_cycles = 0;
            end
            if (mon_en) begin
                if (mgmt_write === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write got addr=%0h data=%08h exp none", mgmt_address, mgmt_writedata);
                    end else begin
                        if ({mgmt_address, mgmt_writedata} !== exp_q[0]) begin
                            failures++;
                            $display("FAIL write_payload got addr=%0h data=%08h exp addr=%0h data=%08h",
                                     mgmt_address, mgmt_writedata, exp_q[0][37:32], exp_q[0][31:0]);
                        end
                        if (mgmt_waitrequest == 1'b0) void'(exp_q.pop_front());
                    end
                end else begin
                    checks++;
                    if (mgmt_write !== 1'b0 || mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0) begin
                        failures++;
                        $display("FAIL idle_bus got wr=%b addr=%0h data=%08h exp 0/0/0", mgmt_write, mgmt_address, mgmt_writedata);
                    end
                end
                if (cfg_ack === 1'b1) begin
                    ack_count++;
                    checks++;
                    if (ready !== 1'b1) begin
                        failures++;
                        $display("FAIL ack_with_ready got ready=%b exp 1", ready);
                    end
                end
            end
        end
    end

    // Driver tasks.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic count_pll_rst(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (ready !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic push_writes(input logic [4:0] sel, input logic [7:0] hi, input logic [7:0] lo);
        exp_q.push_back({6'd0, 32'd0});
        exp_q.push_back({6'd5, 9'd0, sel, 2'b00, hi, lo});
        exp_q.push_back({6'd2, 32'd0});
    endtask

    task automatic issue_req(input logic [4:0] sel, input logic [7:0] hi, input logic [7:0] lo);
        cfg_cnt_sel = sel;
        cfg_hi      = hi;
        cfg_lo      = lo;
        cfg_req     = 1'b1;
        step();
        cfg_req     = 1'b0;
    endtask

    // Reset values, pll_rst width and first lock time.
    task automatic test_reset();
        int n;
        pll_locked = 1'b0;
        pulse_rst();
        mon_en = 1'b1;
        checks++;
        if (pll_rst !== 1'b1 || ready !== 1'b0 || cfg_busy !== 1'b1 || cfg_ack !== 1'b0 ||
            err !== 1'b0 || mgmt_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got rst=%b rdy=%b busy=%b ack=%b err=%b wr=%b exp 1/0/1/0/0/0",
                     pll_rst, ready, cfg_busy, cfg_ack, err, mgmt_write);
        end
        count_pll_rst(n);
        checks++;
        if (n !== RST_CYCLES) begin
            failures++;
            $display("FAIL reset_pll_rst_len got=%0d exp=%0d", n, RST_CYCLES);
        end
        repeat (4) step();
        checks++;
        if (ready !== 1'b0 || cfg_busy !== 1'b1) begin
            failures++;
            $display("FAIL unlocked_not_ready got rdy=%b busy=%b exp 0/1", ready, cfg_busy);
        end
        pll_locked = 1'b1;
        wait_ready(100, n);
        checks++;
        if (n !== 2 + LOCK_STABLE) begin
            failures++;
            $display("FAIL first_lock_time got=%0d exp=%0d", n, 2 + LOCK_STABLE);
        end
        checks++;
        if (cfg_busy !== 1'b0 || cfg_ack !== 1'b0) begin
            failures++;
            $display("FAIL ready_outputs got busy=%b ack=%b exp 0/0", cfg_busy, cfg_ack);
        end
    endtask

    // A one-cycle dropout after 7 stable cycles restarts the stable count.
    task automatic test_lock_glitch();
        int n;
        pll_locked = 1'b0;
        n = 0;
        while (ready === 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL lock_loss_latency got=%0d exp=3", n);
        end
        repeat (4) step();
        pll_locked = 1'b1;
        repeat (7) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_ready(100, n);
        n = n + 8;
        checks++;
        if (n !== 2 + LOCK_STABLE + LOCK_STABLE) begin
            failures++;
            $display("FAIL glitch_relock_time got=%0d exp=%0d", n, 2 + 2 * LOCK_STABLE);
        end
    endtask

    // Full reprogram with stalls; a request while busy must be ignored.
    task automatic test_cfg_write();
        int n;
        int a0;
        a0 = ack_count;
        wait_len = 5;
        push_writes(5'd1, 8'd3, 8'd2);
        issue_req(5'd1, 8'd3, 8'd2);
        n = 1;
        checks++;
        if (cfg_busy !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL accept_busy got busy=%b rdy=%b exp 1/0", cfg_busy, ready);
        end
        cfg_cnt_sel = 5'd2;
        while (cfg_ack !== 1'b1 && n < 200) begin
            cfg_req = (n == 4);
            step();
            n++;
        end
        cfg_req = 1'b0;
        checks++;
        if (n !== 1 + 3 * (wait_len + 1) + LOCK_STABLE) begin
            failures++;
            $display("FAIL cfg_ack_time got=%0d exp=%0d", n, 1 + 3 * (wait_len + 1) + LOCK_STABLE);
        end
        step();
        checks++;
        if (cfg_ack !== 1'b0) begin
            failures++;
            $display("FAIL cfg_ack_pulse got=%b exp 0", cfg_ack);
        end
        checks++;
        if (exp_q.size() !== 0 || ack_count - a0 !== 1) begin
            failures++;
            $display("FAIL cfg_write_done got pending=%0d acks=%0d exp 0/1", exp_q.size(), ack_count - a0);
        end
    endtask

    // Boundary values, zero stall, and a request accepted on the ack cycle.
    task automatic test_back_to_back();
        int n;
        int a0;
        a0 = ack_count;
        wait_len = 0;
        push_writes(5'd17, 8'd0, 8'd0);
        issue_req(5'd17, 8'd0, 8'd0);
        n = 1;
        while (cfg_ack !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n !== 1 + 3 + LOCK_STABLE) begin
            failures++;
            $display("FAIL b2b_first_time got=%0d exp=%0d", n, 1 + 3 + LOCK_STABLE);
        end
        wait_len = 2;
        push_writes(5'd0, 8'hff, 8'hff);
        issue_req(5'd0, 8'hff, 8'hff);
        n = 1;
        while (cfg_ack !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n !== 1 + 9 + LOCK_STABLE) begin
            failures++;
            $display("FAIL b2b_second_time got=%0d exp=%0d", n, 1 + 9 + LOCK_STABLE);
        end
        step();
        checks++;
        if (exp_q.size() !== 0 || ack_count - a0 !== 2) begin
            failures++;
            $display("FAIL b2b_done got pending=%0d acks=%0d exp 0/2", exp_q.size(), ack_count - a0);
        end
    endtask

    // Request on the cycle lock_s falls: lock loss wins, nothing written.
    task automatic test_req_lock_loss();
        int n;
        int a0;
        a0 = ack_count;
        pll_locked = 1'b0;
        step();
        step();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL race_still_ready got=%b exp 1", ready);
        end
        issue_req(5'd3, 8'h44, 8'h55);
        checks++;
        if (ready !== 1'b0 || cfg_busy !== 1'b1 || mgmt_write !== 1'b0) begin
            failures++;
            $display("FAIL race_wait_lock got rdy=%b busy=%b wr=%b exp 0/1/0", ready, cfg_busy, mgmt_write);
        end
        repeat (3) step();
        pll_locked = 1'b1;
        wait_ready(100, n);
        checks++;
        if (n !== 2 + LOCK_STABLE) begin
            failures++;
            $display("FAIL race_relock_time got=%0d exp=%0d", n, 2 + LOCK_STABLE);
        end
        step();
        checks++;
        if (ack_count - a0 !== 0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL race_no_ack got acks=%0d pending=%0d exp 0/0", ack_count - a0, exp_q.size());
        end
    endtask

    // Reset while WR_CNT is stalled abandons the write and the request.
    task automatic test_rst_mid_write();
        int n;
        int a0;
        a0 = ack_count;
        wait_len = 50;
        push_writes(5'd4, 8'h11, 8'h22);
        issue_req(5'd4, 8'h11, 8'h22);
        n = 0;
        while (!(mgmt_write === 1'b1 && mgmt_address === 6'd5) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (mgmt_address !== 6'd5 || mgmt_write !== 1'b1) begin
            failures++;
            $display("FAIL reach_wr_cnt got addr=%0h wr=%b exp 5/1", mgmt_address, mgmt_write);
        end
        repeat (2) step();
        pulse_rst();
        checks++;
        if (mgmt_write !== 1'b0 || pll_rst !== 1'b1 || cfg_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_abandon got wr=%b prst=%b busy=%b exp 0/1/1", mgmt_write, pll_rst, cfg_busy);
        end
        checks++;
        if (exp_q.size() !== 2) begin
            failures++;
            $display("FAIL rst_writes_left got=%0d exp=2", exp_q.size());
        end
        exp_q.delete();
        wait_len = 5;
        count_pll_rst(n);
        checks++;
        if (n !== RST_CYCLES) begin
            failures++;
            $display("FAIL rst_restart_len got=%0d exp=%0d", n, RST_CYCLES);
        end
        wait_ready(100, n);
        checks++;
        if (n !== LOCK_STABLE) begin
            failures++;
            $display("FAIL rst_relock_time got=%0d exp=%0d", n, LOCK_STABLE);
        end
        step();
        checks++;
        if (ack_count - a0 !== 0) begin
            failures++;
            $display("FAIL rst_no_ack got=%0d exp=0", ack_count - a0);
        end
    endtask

    // Lock timeout behaviour (or its absence in the default build).
    task automatic test_timeout();
        int n;
        pll_locked = 1'b0;
        pulse_rst();
        count_pll_rst(n);
        checks++;
        if (n !== RST_CYCLES) begin
            failures++;
            $display("FAIL to_first_rst_len got=%0d exp=%0d", n, RST_CYCLES);
        end
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
        n = 0;
        while (err !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n !== LOCK_TIMEOUT) begin
            failures++;
            $display("FAIL to_err_time got=%0d exp=%0d", n, LOCK_TIMEOUT);
        end
        checks++;
        if (pll_rst !== 1'b0) begin
            failures++;
            $display("FAIL to_state_gap got prst=%b exp 0", pll_rst);
        end
        step();
        count_pll_rst(n);
        checks++;
        if (n !== RST_CYCLES || err !== 1'b1) begin
            failures++;
            $display("FAIL to_retry_rst got len=%0d err=%b exp %0d/1", n, err, RST_CYCLES);
        end
        pll_locked = 1'b1;
        wait_ready(100, n);
        checks++;
        if (n !== 2 + LOCK_STABLE || err !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky got time=%0d err=%b exp %0d/1", n, err, 2 + LOCK_STABLE);
        end
        pulse_rst();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL to_err_clear got=%b exp 0", err);
        end
`else
        repeat (LOCK_TIMEOUT + 50) step();
        checks++;
        if (err !== 1'b0 || pll_rst !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout got err=%b prst=%b rdy=%b exp 0/0/0", err, pll_rst, ready);
        end
        pll_locked = 1'b1;
        wait_ready(100, n);
        checks++;
        if (n !== 2 + LOCK_STABLE) begin
            failures++;
            $display("FAIL no_timeout_lock got=%0d exp=%0d", n, 2 + LOCK_STABLE);
        end
`endif
    endtask

    initial begin
        rst         = 1'b0;
        cfg_req     = 1'b0;
        cfg_cnt_sel = 5'd0;
        cfg_hi      = 8'd0;
        cfg_lo      = 8'd0;
        pll_locked  = 1'b0;
        step();
        test_reset();
        test_lock_glitch();
        test_cfg_write();
        test_back_to_back();
        test_req_lock_loss();
        test_rst_mid_write();
        test_timeout();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
